// File: rtl/channel_sched_if.sv
// Symbol, noise and output streams of the channel scheduler.
// The slave modport is the scheduler's view; master is the surrounding datapath.
interface channel_sched_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        noise_ce;
  logic        noise_valid;
  logic [15:0] noise_good;
  logic [15:0] noise_bad;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  modport master (
    output in_valid, in_data,
    input  in_ready,
    input  noise_ce,
    output noise_valid, noise_good, noise_bad,
    input  out_valid, out_data,
    output out_ready
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready,
    output noise_ce,
    input  noise_valid, noise_good, noise_bad,
    output out_valid, out_data,
    input  out_ready
  );
endinterface

// File: rtl/channel_sched.sv
// Gilbert-Elliott channel sequencer: one symbol per transfer, LFSR-driven good/bad chain.
// Optional bad-symbol/burst statistics are built when CHANNEL_STATS_EN is defined.
module channel_sched #(
  parameter int                LFSR_W = 7,
  parameter logic [LFSR_W-1:0] P_GB   = 7'd6,
  parameter logic [LFSR_W-1:0] P_BB   = 7'd26,
  parameter int                CNT_W  = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              cfg_load,
  input  logic [LFSR_W-1:0] cfg_gb,
  input  logic [LFSR_W-1:0] cfg_bb,
  channel_sched_if.slave    bus,
  output logic              ch_state,
  output logic [CNT_W-1:0]  bad_syms,
  output logic [CNT_W-1:0]  bursts
);

  typedef enum logic [1:0] {IDLE, NOISE, OUT} state_t;

  localparam logic [LFSR_W-1:0] LFSR_INIT = {1'b0, {(LFSR_W-1){1'b1}}};
  localparam logic [LFSR_W-1:0] THR_MAX   = '1;

  state_t            state;
  logic              in_ready_q;
  logic              noise_ce_q;
  logic              out_valid_q;
  logic [15:0]       out_data_q;
  logic [15:0]       sym;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [LFSR_W-1:0] gb;
  logic [LFSR_W-1:0] bb;
  logic              accept;
  logic              gb_pass;
  logic              bb_pass;
  logic              next_state;

  assign bus.in_ready  = in_ready_q;
  assign bus.noise_ce  = noise_ce_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  assign accept    = in_ready_q && bus.in_valid;
  assign lfsr_next = {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_W-2]};

  // An all-ones threshold must pass even for the all-ones LFSR value.
  always_comb begin
    gb_pass    = (gb == THR_MAX) || (lfsr < gb);
    bb_pass    = (bb == THR_MAX) || (lfsr < bb);
    next_state = ch_state;
    case (mode)
      2'd0:    next_state = ch_state;
      2'd1:    next_state = 1'b0;
      2'd2:    next_state = 1'b1;
      default: next_state = ch_state ? bb_pass : gb_pass;
    endcase
  end

  // in_ready comes up one cycle after reset releases, keeping it a pure register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      noise_ce_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sym         <= '0;
      ch_state    <= 1'b0;
      lfsr        <= LFSR_INIT;
      gb          <= P_GB;
      bb          <= P_BB;
    end else begin
      if (cfg_load) begin
        gb <= cfg_gb;
        bb <= cfg_bb;
      end
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            in_ready_q <= 1'b0;
            sym        <= bus.in_data;
            ch_state   <= next_state;
            lfsr       <= lfsr_next;
            if (mode == 2'd0) begin
              out_data_q  <= bus.in_data;
              out_valid_q <= 1'b1;
              state       <= OUT;
            end else begin
              noise_ce_q <= 1'b1;
              state      <= NOISE;
            end
          end
        end
        NOISE: begin
          if (bus.noise_valid) begin
            out_data_q  <= sym + (ch_state ? bus.noise_bad : bus.noise_good);
            noise_ce_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          noise_ce_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef CHANNEL_STATS_EN
  logic [CNT_W-1:0] bad_cnt;
  logic [CNT_W-1:0] burst_cnt;
  logic             out_fire;

  assign out_fire = out_valid_q && bus.out_ready;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bad_cnt   <= '0;
      burst_cnt <= '0;
    end else begin
      if (out_fire && ch_state && (bad_cnt != '1))
        bad_cnt <= bad_cnt + CNT_W'(1);
      if (accept && !ch_state && next_state && (burst_cnt != '1))
        burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

  assign bad_syms = bad_cnt;
  assign bursts   = burst_cnt;
`else
  assign bad_syms = '0;
  assign bursts   = '0;
`endif

endmodule

// File: tb/tb_channel_sched.sv
// Directed self-checking bench for channel_sched; expected values are hand-derived
// from the LFSR sequence 3F,7F,7E,7C,78,70,60,40,01,02,04,08 after reset.
module tb_channel_sched;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        cfg_load;
  logic [6:0]  cfg_gb;
  logic [6:0]  cfg_bb;
  logic        ch_state;
  logic [15:0] bad_syms;
  logic [15:0] bursts;
  int          checks = 0;
  int          fails  = 0;

  channel_sched_if bus ();

  channel_sched dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .mode     (mode),
    .cfg_load (cfg_load),
    .cfg_gb   (cfg_gb),
    .cfg_bb   (cfg_bb),
    .bus      (bus),
    .ch_state (ch_state),
    .bad_syms (bad_syms),
    .bursts   (bursts)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Counters read zero unless the statistics block is compiled in.
  function automatic logic [15:0] exp_cnt(input logic [15:0] n);
`ifdef CHANNEL_STATS_EN
    return n;
`else
    return 16'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wait_ready timeout: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic accept(input logic [15:0] d, input logic [1:0] m,
                        input logic ld, input logic [6:0] g, input logic [6:0] b);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    mode         = m;
    cfg_load     = ld;
    cfg_gb       = g;
    cfg_bb       = b;
    tick();
    bus.in_valid = 1'b0;
    cfg_load     = 1'b0;
  endtask

  task automatic load_cfg(input logic [6:0] g, input logic [6:0] b);
    cfg_load = 1'b1;
    cfg_gb   = g;
    cfg_bb   = b;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("[TB] FAIL rst_in_ready: got %b required 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.noise_ce !== 1'b0) begin fails++; $display("[TB] FAIL rst_noise_ce: got %b required 0", bus.noise_ce); end
    checks++; if (bus.out_data !== 16'h0000) begin fails++; $display("[TB] FAIL rst_out_data: got %h required 0000", bus.out_data); end
    checks++; if (ch_state !== 1'b0) begin fails++; $display("[TB] FAIL rst_ch_state: got %b required 0", ch_state); end
    checks++; if (bad_syms !== 16'h0000) begin fails++; $display("[TB] FAIL rst_bad_syms: got %h required 0000", bad_syms); end
    checks++; if (bursts !== 16'h0000) begin fails++; $display("[TB] FAIL rst_bursts: got %h required 0000", bursts); end
    reset = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL post_rst_in_ready: got %b required 1", bus.in_ready); end
  endtask

  task automatic test_markov_good();
    accept(16'h0100, 2'd3, 1'b0, 7'd0, 7'd0);
    checks++; if (ch_state !== 1'b0) begin fails++; $display("[TB] FAIL good_state: got %b required 0", ch_state); end
    checks++; if (bus.noise_ce !== 1'b1) begin fails++; $display("[TB] FAIL good_noise_ce: got %b required 1", bus.noise_ce); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL good_early_valid: got %b required 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL good_out_valid: got %b required 1", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0110) begin fails++; $display("[TB] FAIL good_out_data: got %h required 0110", bus.out_data); end
    checks++; if (bus.noise_ce !== 1'b0) begin fails++; $display("[TB] FAIL good_noise_ce_off: got %b required 0", bus.noise_ce); end
    handshake();
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL good_valid_drop: got %b required 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL good_ready_back: got %b required 1", bus.in_ready); end
  endtask

  task automatic test_cfg_burst();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    load_cfg(7'd64, 7'd26);
    accept(16'h0200, 2'd3, 1'b0, 7'd0, 7'd0);
    checks++; if (ch_state !== 1'b1) begin fails++; $display("[TB] FAIL burst_state: got %b required 1", ch_state); end
    checks++; if (bursts !== exp_cnt(16'd1)) begin fails++; $display("[TB] FAIL burst_count: got %0d required %0d", bursts, exp_cnt(16'd1)); end
    tick();
    checks++; if (bus.out_data !== 16'h0A00) begin fails++; $display("[TB] FAIL burst_out_data: got %h required 0a00", bus.out_data); end
    handshake();
    checks++; if (bad_syms !== exp_cnt(16'd1)) begin fails++; $display("[TB] FAIL burst_bad_syms: got %0d required %0d", bad_syms, exp_cnt(16'd1)); end
  endtask

  task automatic test_bb_zero();
    load_cfg(7'd64, 7'd0);
    accept(16'h0300, 2'd3, 1'b0, 7'd0, 7'd0);
    checks++; if (ch_state !== 1'b0) begin fails++; $display("[TB] FAIL bb0_leave: got %b required 0", ch_state); end
    tick();
    checks++; if (bus.out_data !== 16'h0310) begin fails++; $display("[TB] FAIL bb0_out_data: got %h required 0310", bus.out_data); end
    handshake();
    for (int i = 0; i < 3; i++) begin
      accept(16'(16'h1000 + i), 2'd2, 1'b0, 7'd0, 7'd0);
      checks++; if (ch_state !== 1'b1) begin fails++; $display("[TB] FAIL force_bad_state[%0d]: got %b required 1", i, ch_state); end
      tick();
      checks++; if (bus.out_data !== 16'(16'h1800 + i)) begin fails++; $display("[TB] FAIL force_bad_data[%0d]: got %h required %h", i, bus.out_data, 16'(16'h1800 + i)); end
      handshake();
    end
    checks++; if (bad_syms !== exp_cnt(16'd4)) begin fails++; $display("[TB] FAIL force_bad_syms: got %0d required %0d", bad_syms, exp_cnt(16'd4)); end
    checks++; if (bursts !== exp_cnt(16'd2)) begin fails++; $display("[TB] FAIL force_bad_bursts: got %0d required %0d", bursts, exp_cnt(16'd2)); end
  endtask

  task automatic test_cfg_coincide();
    accept(16'h0040, 2'd1, 1'b0, 7'd0, 7'd0);
    checks++; if (ch_state !== 1'b0) begin fails++; $display("[TB] FAIL force_good_state: got %b required 0", ch_state); end
    tick();
    checks++; if (bus.out_data !== 16'h0050) begin fails++; $display("[TB] FAIL force_good_data: got %h required 0050", bus.out_data); end
    handshake();
    accept(16'h0050, 2'd3, 1'b1, 7'd127, 7'd0);
    checks++; if (ch_state !== 1'b0) begin fails++; $display("[TB] FAIL coincide_old_thr: got %b required 0", ch_state); end
    tick();
    handshake();
    accept(16'h0060, 2'd3, 1'b0, 7'd0, 7'd0);
    checks++; if (ch_state !== 1'b1) begin fails++; $display("[TB] FAIL new_thr_state: got %b required 1", ch_state); end
    checks++; if (bursts !== exp_cnt(16'd3)) begin fails++; $display("[TB] FAIL new_thr_bursts: got %0d required %0d", bursts, exp_cnt(16'd3)); end
    tick();
    checks++; if (bus.out_data !== 16'h0860) begin fails++; $display("[TB] FAIL new_thr_data: got %h required 0860", bus.out_data); end
    handshake();
    checks++; if (bad_syms !== exp_cnt(16'd5)) begin fails++; $display("[TB] FAIL new_thr_bad_syms: got %0d required %0d", bad_syms, exp_cnt(16'd5)); end
  endtask

  task automatic test_bypass();
    accept(16'hFFFF, 2'd0, 1'b0, 7'd0, 7'd0);
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bypass_valid: got %b required 1", bus.out_valid); end
    checks++; if (bus.out_data !== 16'hFFFF) begin fails++; $display("[TB] FAIL bypass_data: got %h required ffff", bus.out_data); end
    checks++; if (bus.noise_ce !== 1'b0) begin fails++; $display("[TB] FAIL bypass_noise_ce: got %b required 0", bus.noise_ce); end
    checks++; if (ch_state !== 1'b1) begin fails++; $display("[TB] FAIL bypass_state_kept: got %b required 1", ch_state); end
    handshake();
    checks++; if (bus.noise_ce !== 1'b0) begin fails++; $display("[TB] FAIL bypass_noise_ce_end: got %b required 0", bus.noise_ce); end
    checks++; if (bad_syms !== exp_cnt(16'd6)) begin fails++; $display("[TB] FAIL bypass_bad_syms: got %0d required %0d", bad_syms, exp_cnt(16'd6)); end
  endtask

  task automatic test_wrap_hold();
    bus.noise_good = 16'h0002;
    accept(16'hFFFF, 2'd1, 1'b0, 7'd0, 7'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL hold_valid[%0d]: got %b required 1", i, bus.out_valid); end
      checks++; if (bus.out_data !== 16'h0001) begin fails++; $display("[TB] FAIL hold_data[%0d]: got %h required 0001", i, bus.out_data); end
      checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("[TB] FAIL hold_in_ready[%0d]: got %b required 0", i, bus.in_ready); end
      tick();
    end
    handshake();
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL hold_release: got %b required 1", bus.in_ready); end
    bus.noise_good = 16'h0010;
  endtask

  task automatic test_reset_mid();
    bus.noise_valid = 1'b0;
    accept(16'h0700, 2'd3, 1'b0, 7'd0, 7'd0);
    tick();
    checks++; if (bus.noise_ce !== 1'b1) begin fails++; $display("[TB] FAIL mid_noise_wait: got %b required 1", bus.noise_ce); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_no_valid: got %b required 0", bus.out_valid); end
    reset = 1'b1;
    tick();
    checks++; if (bus.noise_ce !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_noise_ce: got %b required 0", bus.noise_ce); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_ready: got %b required 0", bus.in_ready); end
    checks++; if (bad_syms !== 16'h0000) begin fails++; $display("[TB] FAIL mid_rst_bad_syms: got %0d required 0", bad_syms); end
    checks++; if (bursts !== 16'h0000) begin fails++; $display("[TB] FAIL mid_rst_bursts: got %0d required 0", bursts); end
    reset = 1'b0;
    bus.noise_valid = 1'b1;
    tick();
    accept(16'h0100, 2'd3, 1'b0, 7'd0, 7'd0);
    checks++; if (ch_state !== 1'b0) begin fails++; $display("[TB] FAIL mid_replay_state: got %b required 0", ch_state); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL mid_replay_valid: got %b required 1", bus.out_valid); end
    checks++; if (bus.out_data !== 16'h0110) begin fails++; $display("[TB] FAIL mid_replay_data: got %h required 0110", bus.out_data); end
    handshake();
    load_cfg(7'd64, 7'd26);
    accept(16'h0100, 2'd3, 1'b0, 7'd0, 7'd0);
    checks++; if (ch_state !== 1'b0) begin fails++; $display("[TB] FAIL mid_lfsr_restart: got %b required 0", ch_state); end
    tick();
    handshake();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset           = 1'b1;
    mode            = 2'd3;
    cfg_load        = 1'b0;
    cfg_gb          = 7'd0;
    cfg_bb          = 7'd0;
    bus.in_valid    = 1'b0;
    bus.in_data     = 16'h0000;
    bus.noise_valid = 1'b1;
    bus.noise_good  = 16'h0010;
    bus.noise_bad   = 16'h0800;
    bus.out_ready   = 1'b0;
    test_reset();
    test_markov_good();
    test_cfg_burst();
    test_bb_zero();
    test_cfg_coincide();
    test_bypass();
    test_wrap_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
